// File: rtl/bsc_axiu_addr_interleave_slice_if.sv
// One AXI address channel (AR or AW): address, opaque sideband, valid/ready.
// The master drives addr/payload/valid; the slave returns ready.
interface bsc_axiu_addr_interleave_slice_if #(
  parameter int ADDR_WIDTH    = 64,
  parameter int PAYLOAD_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]    addr;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic                     valid;
  logic                     ready;

  modport master (output addr, payload, valid, input ready);
  modport slave  (input addr, payload, valid, output ready);
endinterface

// File: rtl/bsc_axiu_addr_interleave_slice.sv
// Skid-buffered address interleaver with run-time stride/enable: 1-cycle latency, full throughput.
// Backpressure: s.ready is registered, drops once the skid fills or a config change is pending.
module bsc_axiu_addr_interleave_slice #(
  parameter int                    ADDR_WIDTH          = 64,
  parameter int                    PAYLOAD_WIDTH       = 32,
  parameter int                    NUM_BANKS_LOG2      = 2,
  parameter int                    BANK_SIZE_LOG2      = 34,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR           = '0,
  parameter int                    DEFAULT_STRIDE_LOG2 = 13,
  parameter bit                    DEFAULT_ENABLE      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  input  logic       cfg_enable,
  input  logic [5:0] cfg_stride_log2,
  output logic       cfg_pending,
  output logic       cfg_err,
  bsc_axiu_addr_interleave_slice_if.slave  s,
  bsc_axiu_addr_interleave_slice_if.master m
);
  localparam int                    WIN   = BANK_SIZE_LOG2 + NUM_BANKS_LOG2;
  localparam logic [ADDR_WIDTH-1:0] NMASK = (ADDR_WIDTH'(1) << NUM_BANKS_LOG2) - ADDR_WIDTH'(1);
  localparam logic [6:0]            MAX_S = 7'(BANK_SIZE_LOG2 - NUM_BANKS_LOG2);
  localparam logic [5:0]            DEF_S = 6'(DEFAULT_STRIDE_LOG2);

  logic                     r_act_en, r_shd_en, r_pending, r_cfg_err;
  logic [5:0]               r_act_stride, r_shd_stride;
  logic                     r_s_rdy, r_m_vld, r_sk_vld;
  logic [ADDR_WIDTH-1:0]    r_m_addr, r_sk_addr;
  logic [PAYLOAD_WIDTH-1:0] r_m_pay, r_sk_pay;

  logic                     w_s_fire, w_load_main, w_sk_vld_nxt;
  logic                     w_legal, w_cfg_take, w_apply, w_pend_nxt;
  logic [ADDR_WIDTH-1:0]    w_remap;

  // In-window addresses get the bank-select field exchanged with the N bits at the stride.
  function automatic logic [ADDR_WIDTH-1:0] f_remap(input logic [ADDR_WIDTH-1:0] addr,
                                                    input logic en, input logic [5:0] sl);
    logic [ADDR_WIDTH-1:0] off, sel, bnk, kept;
    off  = addr - BASE_ADDR;
    sel  = (off >> sl) & NMASK;
    bnk  = (off >> BANK_SIZE_LOG2) & NMASK;
    kept = off & ~(NMASK << sl) & ~(NMASK << BANK_SIZE_LOG2);
    if (en && (addr >= BASE_ADDR) && ((off >> WIN) == '0))
      return BASE_ADDR + (kept | (bnk << sl) | (sel << BANK_SIZE_LOG2));
    return addr;
  endfunction

  always_comb begin
    w_s_fire     = s.valid & r_s_rdy;
    w_load_main  = ~r_m_vld | m.ready;
    // A skid beat always moves to main first; s.ready is low whenever the skid is full.
    w_sk_vld_nxt = w_load_main ? 1'b0 : (r_sk_vld | w_s_fire);
    w_legal      = (cfg_stride_log2 >= 6'd12) && ({1'b0, cfg_stride_log2} <= MAX_S);
    w_cfg_take   = cfg_valid & w_legal;
    w_apply      = r_pending & ~r_m_vld & ~r_sk_vld;
    w_pend_nxt   = w_cfg_take | (r_pending & ~w_apply);
    w_remap      = f_remap(s.addr, r_act_en, r_act_stride);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_en     <= DEFAULT_ENABLE;
      r_act_stride <= DEF_S;
      r_shd_en     <= DEFAULT_ENABLE;
      r_shd_stride <= DEF_S;
      r_pending    <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_s_rdy      <= 1'b0;
      r_m_vld      <= 1'b0;
      r_m_addr     <= '0;
      r_m_pay      <= '0;
      r_sk_vld     <= 1'b0;
      r_sk_addr    <= '0;
      r_sk_pay     <= '0;
    end else begin
      r_cfg_err <= cfg_valid & ~w_legal;
      r_pending <= w_pend_nxt;
      r_s_rdy   <= ~w_sk_vld_nxt & ~w_pend_nxt;
      r_sk_vld  <= w_sk_vld_nxt;
      if (w_cfg_take) begin
        r_shd_en     <= cfg_enable;
        r_shd_stride <= cfg_stride_log2;
      end
      if (w_apply) begin
        r_act_en     <= r_shd_en;
        r_act_stride <= r_shd_stride;
      end
      if (w_load_main) begin
        if (r_sk_vld) begin
          r_m_vld  <= 1'b1;
          r_m_addr <= r_sk_addr;
          r_m_pay  <= r_sk_pay;
        end else if (w_s_fire) begin
          r_m_vld  <= 1'b1;
          r_m_addr <= w_remap;
          r_m_pay  <= s.payload;
        end else begin
          r_m_vld  <= 1'b0;
        end
      end else if (w_s_fire) begin
        r_sk_addr <= w_remap;
        r_sk_pay  <= s.payload;
      end
    end
  end

  assign s.ready     = r_s_rdy;
  assign m.valid     = r_m_vld;
  assign m.addr      = r_m_addr;
  assign m.payload   = r_m_pay;
  assign cfg_pending = r_pending;
  assign cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_bsc_axiu_addr_interleave_slice.sv
// Bench for the address interleave slice: vector table plus hand-written multi-cycle sequences.
// Expected beats are queued at accept time and popped by a monitor as m_* handshakes.
module tb_bsc_axiu_addr_interleave_slice;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_enable = 1'b0;
  logic [5:0] cfg_stride_log2 = 6'd0;
  logic       cfg_pending, cfg_err;
  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;

  bsc_axiu_addr_interleave_slice_if #(.ADDR_WIDTH(64), .PAYLOAD_WIDTH(32)) s_if ();
  bsc_axiu_addr_interleave_slice_if #(.ADDR_WIDTH(64), .PAYLOAD_WIDTH(32)) m_if ();

  bsc_axiu_addr_interleave_slice dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_valid       (cfg_valid),
    .cfg_enable      (cfg_enable),
    .cfg_stride_log2 (cfg_stride_log2),
    .cfg_pending     (cfg_pending),
    .cfg_err         (cfg_err),
    .s               (s_if),
    .m               (m_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] pay;
    int          cyc;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [63:0] addr;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: pops the scoreboard on every m_* handshake and checks stall stability.
  initial begin
    bit          hold_vld = 1'b0;
    logic [63:0] hold_addr = '0;
    logic [31:0] hold_pay = '0;
    sb_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld && m_if.valid) begin
          chk("hold_addr", m_if.addr, hold_addr);
          chk("hold_payload", 64'(m_if.payload), 64'(hold_pay));
        end
        hold_vld  = m_if.valid && !m_if.ready;
        hold_addr = m_if.addr;
        hold_pay  = m_if.payload;
        if (m_if.valid && m_if.ready) begin
          if (sbq.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_beat: got addr 0x%0h, expected no beat", m_if.addr);
          end else begin
            e = sbq.pop_front();
            chk("out_addr", m_if.addr, e.addr);
            chk("out_payload", 64'(m_if.payload), 64'(e.pay));
            if (e.cyc >= 0) chk("out_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [63:0] a, input logic [31:0] p, input logic [63:0] ea,
                      input bit push, input bit timed);
    bit done = 1'b0;
    s_if.valid   = 1'b1;
    s_if.addr    = a;
    s_if.payload = p;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (s_if.ready) begin
        if (push) sbq.push_back('{addr: ea, pay: p, cyc: timed ? cyc + 1 : -1});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_if.valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: got s_ready=0 for 50 cycles, expected accept of 0x%0h", a);
    end
  endtask

  task automatic cfg(input bit en, input logic [5:0] st);
    cfg_valid       = 1'b1;
    cfg_enable      = en;
    cfg_stride_log2 = st;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_applied();
    int i = 0;
    @(negedge clk);
    while (cfg_pending && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("cfg_applied", 64'(cfg_pending), 64'd0);
    chk("ready_after_apply", 64'(s_if.ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{64'h0000_0000_0000_2000, 64'h0000_0004_0000_0000};
    vecs[1] = '{64'h0000_0000_0000_6000, 64'h0000_000C_0000_0000};
    vecs[2] = '{64'h0000_0004_0000_0000, 64'h0000_0000_0000_2000};
    vecs[3] = '{64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000};
    vecs[4] = '{64'h0000_0000_0000_E000, 64'h0000_000C_0000_8000};
    vecs[5] = '{64'h0000_000F_0000_1234, 64'h0000_0003_0000_7234};
    vecs[6] = '{64'h0000_0010_0000_0000, 64'h0000_0010_0000_0000};
    vecs[7] = '{64'h0000_000F_FFFF_FFFF, 64'h0000_000F_FFFF_FFFF};

    s_if.valid = 1'b0;
    s_if.addr = '0;
    s_if.payload = '0;
    m_if.ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_m_valid", 64'(m_if.valid), 64'd0);
    chk("rst_m_addr", m_if.addr, 64'd0);
    chk("rst_m_payload", 64'(m_if.payload), 64'd0);
    chk("rst_s_ready", 64'(s_if.ready), 64'd0);
    chk("rst_cfg_pending", 64'(cfg_pending), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_during_first_cycle", 64'(s_if.ready), 64'd0);
    @(negedge clk);
    chk("s_ready_after_rst", 64'(s_if.ready), 64'd1);
    @(posedge clk);
    #1;

    // Default remap, back-to-back with 1-cycle latency
    for (int i = 0; i < 8; i++) send(vecs[i].addr, 32'hA000_0000 + 32'(i), vecs[i].exp, 1'b1, 1'b1);
    wait_drain();

    // Backpressure: only two beats fit
    m_if.ready = 1'b0;
    send(64'h2000, 32'hB000_0001, 64'h4_0000_0000, 1'b1, 1'b0);
    send(64'h6000, 32'hB000_0002, 64'hC_0000_0000, 1'b1, 1'b0);
    s_if.valid = 1'b1;
    s_if.addr = 64'h4_0000_0000;
    s_if.payload = 32'hB000_0003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_s_ready_low", 64'(s_if.ready), 64'd0);
      chk("bp_m_valid", 64'(m_if.valid), 64'd1);
    end
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    m_if.ready = 1'b1;
    wait_drain();

    // Illegal configs leave the default stride in place
    cfg(1'b1, 6'd11);
    @(negedge clk);
    chk("err_pulse_11", 64'(cfg_err), 64'd1);
    chk("err_no_pending_11", 64'(cfg_pending), 64'd0);
    @(negedge clk);
    chk("err_single_11", 64'(cfg_err), 64'd0);
    @(posedge clk);
    #1;
    cfg(1'b1, 6'd33);
    @(negedge clk);
    chk("err_pulse_33", 64'(cfg_err), 64'd1);
    chk("err_no_pending_33", 64'(cfg_pending), 64'd0);
    @(negedge clk);
    chk("err_single_33", 64'(cfg_err), 64'd0);
    @(posedge clk);
    #1;
    send(64'h2000, 32'hC000_0001, 64'h4_0000_0000, 1'b1, 1'b1);
    wait_drain();

    // Config change with two beats buffered
    m_if.ready = 1'b0;
    send(64'h2000, 32'hD000_0001, 64'h4_0000_0000, 1'b1, 1'b0);
    send(64'h6000, 32'hD000_0002, 64'hC_0000_0000, 1'b1, 1'b0);
    cfg(1'b1, 6'd12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cc_pending", 64'(cfg_pending), 64'd1);
      chk("cc_s_ready_low", 64'(s_if.ready), 64'd0);
    end
    @(posedge clk);
    #1;
    m_if.ready = 1'b1;
    wait_applied();
    chk("cc_drained", 64'(sbq.size()), 64'd0);
    send(64'h1000, 32'hD000_0003, 64'h4_0000_0000, 1'b1, 1'b1);
    send(64'h2000, 32'hD000_0004, 64'h8_0000_0000, 1'b1, 1'b1);
    wait_drain();

    // Disable: addresses pass through
    cfg(1'b0, 6'd13);
    wait_applied();
    send(64'h2000, 32'hE000_0001, 64'h2000, 1'b1, 1'b1);
    send(64'h6000, 32'hE000_0002, 64'h6000, 1'b1, 1'b1);
    wait_drain();

    // Reset with main and skid full: nothing may come out
    m_if.ready = 1'b0;
    send(64'h1000, 32'hF000_0001, 64'h0, 1'b0, 1'b0);
    send(64'h3000, 32'hF000_0002, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_s_ready", 64'(s_if.ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_if.ready = 1'b1;
    @(negedge clk);
    chk("rst2_m_valid", 64'(m_if.valid), 64'd0);
    chk("rst2_s_ready_low", 64'(s_if.ready), 64'd0);
    @(negedge clk);
    chk("rst2_s_ready_high", 64'(s_if.ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst2_no_beat", 64'(m_if.valid), 64'd0);
    end
    chk("final_queue_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
